// File: rtl/mult_client_pkg.sv
// Shared definitions for the multiplier initiator: FSM encodings and default widths.
package mult_client_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/mult_client_op_fifo.sv
// Operand-pair buffer: synchronous FIFO with registered full/empty and a
// one-cycle overflow pulse for pushes dropped while full.
module mult_op_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, empty_q, ovf_q;
  logic             do_push, do_pop;

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
      ovf_q   <= push_i && !do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mult_client.sv
// Initiator for the shift-add multiplier: buffers operand pairs, issues them one
// at a time, captures and acknowledges each product, and offers it downstream.
module mult_client
  import mult_client_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_W      = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPush,
  input  logic [DATA_W-1:0] iOp_A,
  input  logic [DATA_W-1:0] iOp_B,
  output logic              oFull,
  output logic              oOverflow,
  output logic [DATA_W-1:0] oData_A,
  output logic [DATA_W-1:0] oData_B,
  output logic              oValid_Data,
  output logic              oAcknoledged,
  input  logic              iMult_Idle,
  input  logic              iMult_Done,
  input  logic [DATA_W-1:0] iMult_Result,
  output logic [DATA_W-1:0] oResult,
  output logic              oResult_Valid,
  input  logic              iResult_Ready
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                res_vld_q, res_vld_d;
  logic                pop, capture, slot_free, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;

  mult_op_fifo #(
    .W     (2*DATA_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push_i     (iPush),
    .pop_i      (pop),
    .wdata_i    ({iOp_A, iOp_B}),
    .rdata_o    (fifo_rdata),
    .full_o     (oFull),
    .empty_o    (fifo_empty),
    .overflow_o (oOverflow)
  );

  assign slot_free = !res_vld_q || iResult_Ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      // A DONE seen here belongs to a request issued before a client-only
      // reset; acknowledge it without capturing so the multiplier returns idle.
      ST_FETCH: begin
        if (iMult_Done) begin
          state_d = ST_ACK;
        end else if (!fifo_empty && iMult_Idle) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iMult_Done && slot_free) begin
          capture = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:   state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    res_d     = res_q;
    res_vld_d = res_vld_q && !iResult_Ready;
    if (pop) {data_a_d, data_b_d} = fifo_rdata;
    if (capture) begin
      res_d     = iMult_Result;
      res_vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      data_a_q  <= '0;
      data_b_q  <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign oValid_Data   = (state_q == ST_ISSUE);
  assign oAcknoledged  = (state_q == ST_ACK);
  assign oData_A       = data_a_q;
  assign oData_B       = data_b_q;
  assign oResult       = res_q;
  assign oResult_Valid = res_vld_q;

endmodule

// File: tb/tb_mult_client.sv
// Scoreboard bench for mult_client against a behavioural multiplier that has
// its own reset, so client-only resets can strand it in DONE.
module tb_mult_client;

  localparam int DW  = 32;
  localparam int LAT = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          mrst  = 1'b1;
  logic          iPush = 1'b0;
  logic [DW-1:0] iOp_A = '0, iOp_B = '0;
  logic          iResult_Ready = 1'b1;
  logic          oFull, oOverflow, oValid_Data, oAcknoledged, oResult_Valid;
  logic [DW-1:0] oData_A, oData_B, oResult;
  logic          m_idle, m_done;
  logic [DW-1:0] m_res;

  always #5 Clock = ~Clock;

  mult_client dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iPush         (iPush),
    .iOp_A         (iOp_A),
    .iOp_B         (iOp_B),
    .oFull         (oFull),
    .oOverflow     (oOverflow),
    .oData_A       (oData_A),
    .oData_B       (oData_B),
    .oValid_Data   (oValid_Data),
    .oAcknoledged  (oAcknoledged),
    .iMult_Idle    (m_idle),
    .iMult_Done    (m_done),
    .iMult_Result  (m_res),
    .oResult       (oResult),
    .oResult_Valid (oResult_Valid),
    .iResult_Ready (iResult_Ready)
  );

  // Behavioural multiplier: IDLE -> BUSY (LAT cycles) -> DONE until acknowledged.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mst_e;
  mst_e          mst;
  int            mcnt;
  logic [DW-1:0] ma, mb;

  always @(posedge Clock or posedge mrst) begin
    if (mrst) begin
      mst <= M_IDLE; mcnt <= 0; m_res <= '0; ma <= '0; mb <= '0;
    end else begin
      case (mst)
        M_IDLE: if (oValid_Data) begin
          ma <= oData_A; mb <= oData_B; mcnt <= LAT; mst <= M_BUSY;
        end
        M_BUSY: if (mcnt == 1) begin
          m_res <= ma * mb; mst <= M_DONE;
        end else mcnt <= mcnt - 1;
        M_DONE: if (oAcknoledged) mst <= M_IDLE;
        default: mst <= M_IDLE;
      endcase
    end
  end
  assign m_idle = (mst == M_IDLE);
  assign m_done = (mst == M_DONE);

  logic [2*DW-1:0] exp_ops[$];
  logic [DW-1:0]   exp_res[$];
  int checks = 0, errors = 0;
  int n_issue = 0, n_ack = 0, n_vld = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit acc, input bit has_res);
    iPush = 1'b1; iOp_A = a; iOp_B = b;
    if (acc) begin
      exp_ops.push_back({a, b});
      if (has_res) exp_res.push_back(a * b);
    end
    tick();
    iPush = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && (exp_res.size() != 0 || exp_ops.size() != 0); i++) tick();
    chk("drain_left", 32'(exp_res.size() + exp_ops.size()), 32'd0);
  endtask

  task automatic monitor();
    logic [2*DW-1:0] eo;
    logic [DW-1:0]   er, prev_res;
    bit              prev_stall, prev_v, prev_a;
    prev_stall = 0; prev_v = 0; prev_a = 0; prev_res = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prev_stall = 0; prev_v = 0; prev_a = 0;
      end else begin
        if (oValid_Data) begin
          n_issue++;
          if (exp_ops.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
          else begin
            eo = exp_ops.pop_front();
            chk("issue_A", oData_A, eo[2*DW-1:DW]);
            chk("issue_B", oData_B, eo[DW-1:0]);
          end
        end
        if (oAcknoledged) n_ack++;
        if (oValid_Data || oAcknoledged)
          chk("strobe_rule", 32'((oValid_Data && oAcknoledged) || (oValid_Data && prev_v) ||
                                 (oAcknoledged && prev_a)), 32'd0);
        if (oResult_Valid) n_vld++;
        if (prev_stall && oResult_Valid) chk("result_frozen", oResult, prev_res);
        if (oResult_Valid && iResult_Ready) begin
          if (exp_res.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
          else begin
            er = exp_res.pop_front();
            chk("result", oResult, er);
          end
        end
        prev_stall = oResult_Valid && !iResult_Ready;
        prev_res   = oResult;
        prev_v     = oValid_Data;
        prev_a     = oAcknoledged;
      end
    end
  endtask

  int i0, a0, v0;

  initial begin
    fork monitor(); join_none

    // Reset state
    repeat (2) tick();
    chk("rst_data_a", oData_A, '0);
    chk("rst_data_b", oData_B, '0);
    chk("rst_result", oResult, '0);
    chk("rst_flags", 32'({oFull, oOverflow, oValid_Data, oAcknoledged, oResult_Valid}), 32'd0);
    Reset = 1'b0; mrst = 1'b0;
    tick();

    // Single product through an idle system
    i0 = n_issue; a0 = n_ack; v0 = n_vld;
    push(32'd3, 32'd5, 1, 1);
    wait_drain(100);
    repeat (3) tick();
    chk("t1_issues", 32'(n_issue - i0), 32'd1);
    chk("t1_acks",   32'(n_ack - a0),   32'd1);
    chk("t1_valid_cycles", 32'(n_vld - v0), 32'd1);

    // Fill the buffer while the first pair is in flight; backpressure the output
    iResult_Ready = 1'b0;
    push(32'd2, 32'd3, 1, 1);
    push(32'd7, 32'd6, 1, 1);
    push(32'h0000FFFF, 32'h00010001, 1, 1);
    push(32'd0, 32'd9, 1, 1);
    push(32'd5, 32'd5, 1, 1);
    chk("full_after_fill", 32'(oFull), 32'd1);
    push(32'd9, 32'd9, 0, 0);
    chk("overflow_pulse", 32'(oOverflow), 32'd1);
    tick();
    chk("overflow_one_cycle", 32'(oOverflow), 32'd0);

    repeat (30) tick();
    a0 = n_ack;
    repeat (10) tick();
    chk("bp_no_ack", 32'(n_ack - a0), 32'd0);
    chk("bp_result", oResult, 32'd6);
    chk("bp_valid", 32'(oResult_Valid), 32'd1);
    chk("bp_mult_done", 32'(m_done), 32'd1);
    push(32'd6, 32'd7, 1, 1);
    chk("refull", 32'(oFull), 32'd1);

    // Release: 6 consumed and 42 captured on the same edge
    iResult_Ready = 1'b1;
    tick();
    chk("swap_valid", 32'(oResult_Valid), 32'd1);
    chk("swap_result", oResult, 32'd42);
    chk("swap_ack", 32'(oAcknoledged), 32'd1);
    tick();
    // FETCH cycle with the buffer full: push and pop together
    push(32'd8, 32'd8, 1, 1);
    chk("pushpop_full", 32'(oFull), 32'd1);
    chk("pushpop_no_ovf", 32'(oOverflow), 32'd0);
    wait_drain(300);

    // Client-only reset mid-WAIT; stale DONE must be flushed without capture
    push(32'd7, 32'd7, 1, 0);
    repeat (4) tick();
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_data", oData_A | oData_B, '0);
    chk("mid_rst_result", oResult, '0);
    chk("mid_rst_flags", 32'({oFull, oOverflow, oValid_Data, oAcknoledged, oResult_Valid}), 32'd0);
    tick();
    Reset = 1'b0;
    a0 = n_ack; v0 = n_vld;
    repeat (20) tick();
    chk("flush_ack", 32'(n_ack - a0), 32'd1);
    chk("flush_no_valid", 32'(n_vld - v0), 32'd0);
    chk("flush_mult_idle", 32'(m_idle), 32'd1);
    push(32'd4, 32'd4, 1, 1);
    wait_drain(100);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
